// File: rtl/dadd_out_buf_if.sv
// Bundle of the write-side strobe/payload, the first-word-fall-through read
// side and the status/overflow signals of dadd_out_buf.
interface dadd_out_buf_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              buf_in_en;
  logic [DWIDTH-1:0] buf_in;
  logic [AWIDTH-1:0] buf_in_addr;
  logic              buf_out_valid;
  logic              buf_out_ready;
  logic [DWIDTH-1:0] buf_out;
  logic [AWIDTH-1:0] buf_out_addr;
  logic [CW-1:0]     buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic              buf_ovf;
  logic              buf_ovf_clr;
  logic [15:0]       buf_drop_cnt;

  // producer / consumer side
  modport master (
    output buf_in_en, buf_in, buf_in_addr, buf_out_ready, buf_ovf_clr,
    input  buf_out_valid, buf_out, buf_out_addr, buf_count,
           buf_full, buf_empty, buf_ovf, buf_drop_cnt
  );

  // buffer side
  modport slave (
    input  buf_in_en, buf_in, buf_in_addr, buf_out_ready, buf_ovf_clr,
    output buf_out_valid, buf_out, buf_out_addr, buf_count,
           buf_full, buf_empty, buf_ovf, buf_drop_cnt
  );
endinterface

// File: rtl/dadd_out_buf.sv
// Output buffer for dadd results: circular FIFO of {addr, data} entries with
// first-word-fall-through read, simultaneous push/pop when full, and a sticky
// overflow flag plus saturating drop counter for writes lost while full.
module dadd_out_buf #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 8
) (
  input logic          clk,
  input logic          rst_n,
  dadd_out_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DWIDTH-1:0] r_data [DEPTH];
  logic [AWIDTH-1:0] r_addr [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic [15:0]       r_drop_cnt;

  logic w_full, w_empty, w_pop, w_push, w_drop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Pop only ever uses the registered head, so a push into an empty FIFO
  // cannot leave in the same cycle.
  assign w_pop   = !w_empty && bus.buf_out_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_push  = bus.buf_in_en && (!w_full || w_pop);
  assign w_drop  = bus.buf_in_en && w_full && !w_pop;

  // Payload storage; no reset, entries are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= bus.buf_in;
      r_addr[r_wr_ptr] <= bus.buf_in_addr;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow and saturating drop count; a drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (bus.buf_ovf_clr)           r_drop_cnt <= 16'd1;
      else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end else if (bus.buf_ovf_clr) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign bus.buf_out_valid = !w_empty;
  assign bus.buf_out       = w_empty ? '0 : r_data[r_rd_ptr];
  assign bus.buf_out_addr  = w_empty ? '0 : r_addr[r_rd_ptr];
  assign bus.buf_count     = r_count;
  assign bus.buf_full      = w_full;
  assign bus.buf_empty     = w_empty;
  assign bus.buf_ovf       = r_ovf;
  assign bus.buf_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_dadd_out_buf.sv
// Bench for dadd_out_buf: directed scenarios plus random traffic, checked by
// a queue-based model (model update at posedge, monitor compare at negedge).
module tb_dadd_out_buf;
  localparam int AW = 32, DW = 32, DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dadd_out_buf_if #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) bus ();

  dadd_out_buf #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // model state: queue of {addr,data}, sticky flag, drop count
  logic [63:0] q[$];
  bit          m_ovf;
  int          m_drop;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit en, input logic [31:0] d, input logic [31:0] a,
                      input bit rdy, input bit clr);
    @(posedge clk); #1;
    bus.buf_in_en     = en;
    bus.buf_in        = d;
    bus.buf_in_addr   = a;
    bus.buf_out_ready = rdy;
    bus.buf_ovf_clr   = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " count"}, 64'(bus.buf_count), 0);
    chk({tag, " valid"}, 64'(bus.buf_out_valid), 0);
    chk({tag, " empty"}, 64'(bus.buf_empty), 1);
    chk({tag, " full"},  64'(bus.buf_full), 0);
    chk({tag, " data"},  64'(bus.buf_out), 0);
    chk({tag, " addr"},  64'(bus.buf_out_addr), 0);
    chk({tag, " ovf"},   64'(bus.buf_ovf), 0);
    chk({tag, " drop"},  64'(bus.buf_drop_cnt), 0);
  endtask

  // Reference model: FIFO rules applied with a queue at each clock edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        bit pop, push, drop;
        pop  = (q.size() > 0) && bus.buf_out_ready;
        push = bus.buf_in_en && (q.size() < DEPTH || pop);
        drop = bus.buf_in_en && !push;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({bus.buf_in_addr, bus.buf_in});
        if (drop) begin
          m_ovf  = 1;
          m_drop = bus.buf_ovf_clr ? 1 : (m_drop < 16'hFFFF ? m_drop + 1 : m_drop);
        end else if (bus.buf_ovf_clr) begin
          m_ovf  = 0;
          m_drop = 0;
        end
      end
    end
  end

  // Monitor: mid-cycle compare of everything the DUT presents.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int n;
        n = q.size();
        chk("valid", 64'(bus.buf_out_valid), 64'(n > 0));
        chk("count", 64'(bus.buf_count), 64'(n));
        chk("full",  64'(bus.buf_full), 64'(n == DEPTH));
        chk("empty", 64'(bus.buf_empty), 64'(n == 0));
        chk("ovf",   64'(bus.buf_ovf), 64'(m_ovf));
        chk("drop",  64'(bus.buf_drop_cnt), 64'(m_drop));
        if (n > 0) begin
          chk("head_data", 64'(bus.buf_out), 64'(q[0][31:0]));
          chk("head_addr", 64'(bus.buf_out_addr), 64'(q[0][63:32]));
        end else begin
          chk("idle_data", 64'(bus.buf_out), 0);
          chk("idle_addr", 64'(bus.buf_out_addr), 0);
        end
      end
    end
  end

  initial begin
    bus.buf_in_en = 0; bus.buf_in = 0; bus.buf_in_addr = 0;
    bus.buf_out_ready = 0; bus.buf_ovf_clr = 0;
    m_ovf = 0; m_drop = 0;
    #12;
    chk_reset_outputs("rst");
    @(posedge clk); #2 rst_n = 1'b1;

    // single write, FWFT head, then pop to empty
    tick(1, 32'h11, 32'h4, 0, 0);
    idle(2);
    tick(0, 0, 0, 1, 0);
    idle(2);

    // fill 1..8 then drain in order
    for (int i = 1; i <= 8; i++) tick(1, i, 32'h100 + i, 0, 0);
    idle(1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0);
    idle(2);

    // overflow: 3 dropped writes, contents intact, then clear
    for (int i = 1; i <= 8; i++) tick(1, i, 32'h200 + i, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 32'hA0 + i, 32'hBAD, 0, 0);
    idle(1);
    tick(0, 0, 0, 0, 1);
    idle(1);

    // full push+pop: count stays 8, no drop, 0x99 lands at the tail
    tick(1, 32'h99, 32'h999, 1, 0);
    idle(1);
    // drop with clear in the same cycle: set wins, count restarts at 1
    tick(1, 32'hEE, 32'hE, 0, 1);
    idle(1);
    tick(1, 32'hEF, 32'hE, 0, 0);
    idle(1);
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 1, 0);
    idle(1);

    // wrap: 20 push/pop pairs with ready held high
    for (int i = 0; i < 20; i++) tick(1, 32'h300 + i, 32'h30 + i, 1, 0);
    idle(2);

    // async reset with 5 entries held
    for (int i = 0; i < 5; i++) tick(1, 32'h500 + i, i, 0, 0);
    tick(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    q.delete(); m_ovf = 0; m_drop = 0;
    #1 rst_n = 1'b1;
    tick(1, 32'h77, 32'h7, 0, 0);
    idle(2);
    tick(0, 0, 0, 1, 0);
    idle(1);

    // random traffic, balanced then producer-heavy to hit full/drop
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 99) < 60, $urandom, $urandom,
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 99) < 80, $urandom, $urandom,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3);
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 1, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
